// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX register and the EX stage.
// Decode-slot inputs, pipeline control, forwarding sources and the
// ALU-facing outputs travel together. The stage uses the slave view.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             id_valid;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [REGW-1:0]  id_rs;
  logic [REGW-1:0]  id_rt;
  logic [REGW-1:0]  id_rd;
  logic [1:0]       id_alu_op;
  logic [5:0]       id_funct;
  logic             id_alu_src;
  logic             id_reg_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_mem_to_reg;
  logic             flush;
  logic             hold;
  logic             exmem_reg_write;
  logic [REGW-1:0]  exmem_rd;
  logic [WIDTH-1:0] exmem_alu_out;
  logic             memwb_reg_write;
  logic [REGW-1:0]  memwb_rd;
  logic [WIDTH-1:0] memwb_data;
  logic             stall;
  logic             ex_valid;
  logic [2:0]       ex_alu_ctrl;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [WIDTH-1:0] ex_store_data;
  logic [REGW-1:0]  ex_dest;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic             ex_illegal;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, flush, hold,
           exmem_reg_write, exmem_rd, exmem_alu_out,
           memwb_reg_write, memwb_rd, memwb_data,
    input  stall, ex_valid, ex_alu_ctrl, ex_a, ex_b, ex_store_data, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, flush, hold,
           exmem_reg_write, exmem_rd, exmem_alu_out,
           memwb_reg_write, memwb_rd, memwb_data,
    output stall, ex_valid, ex_alu_ctrl, ex_a, ex_b, ex_store_data, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU of the 5-stage MIPS core.
// Registers decoded operands/control, decodes AluCtrl at capture time,
// forwards EX/MEM and MEM/WB results onto the registered operands and
// raises a one-cycle stall (with bubble) on a load-use dependency.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  logic             valid_r;
  logic [WIDTH-1:0] rs_data_r;
  logic [WIDTH-1:0] rt_data_r;
  logic [WIDTH-1:0] imm_r;
  logic [REGW-1:0]  rs_r;
  logic [REGW-1:0]  rt_r;
  logic [REGW-1:0]  dest_r;
  logic [2:0]       alu_ctrl_r;
  logic             illegal_r;
  logic             alu_src_r;
  logic             reg_write_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic             mem_to_reg_r;

  logic [3:0]       dec_s;      // {unknown funct, AluCtrl}
  logic             stall_s;
  logic             bubble_s;
  logic [WIDTH-1:0] fwd_rs_s;
  logic [WIDTH-1:0] fwd_rt_s;

  // Main-decoder op class plus funct to {unknown, AluCtrl}.
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] res;
    res = {1'b0, 3'b010};
    case (op)
      2'b00: res = {1'b0, 3'b010};
      2'b01: res = {1'b0, 3'b110};
      2'b11: res = {1'b0, 3'b001};
      2'b10: begin
        case (funct)
          6'b100000: res = {1'b0, 3'b010};
          6'b100010: res = {1'b0, 3'b110};
          6'b100100: res = {1'b0, 3'b000};
          6'b100101: res = {1'b0, 3'b001};
          6'b101010: res = {1'b0, 3'b111};
          default:   res = {1'b1, 3'b011};
        endcase
      end
      default: res = {1'b0, 3'b010};
    endcase
    return res;
  endfunction

  // Youngest matching producer wins; register $0 is never forwarded.
  function automatic logic [WIDTH-1:0] forward_pick(
    input logic [REGW-1:0]  idx,
    input logic [WIDTH-1:0] reg_val,
    input logic             em_we,
    input logic [REGW-1:0]  em_rd,
    input logic [WIDTH-1:0] em_val,
    input logic             mw_we,
    input logic [REGW-1:0]  mw_rd,
    input logic [WIDTH-1:0] mw_val
  );
    logic [WIDTH-1:0] res;
    res = reg_val;
    if (em_we && (em_rd != {REGW{1'b0}}) && (em_rd == idx)) begin
      res = em_val;
    end else if (mw_we && (mw_rd != {REGW{1'b0}}) && (mw_rd == idx)) begin
      res = mw_val;
    end else begin
      res = reg_val;
    end
    return res;
  endfunction

  // Decode ALU control for the instruction waiting in the decode slot.
  always_comb begin
    dec_s = alu_decode(bus.id_alu_op, bus.id_funct);
  end

  // Load-use detection: a valid load in EX whose dest feeds decode's rs/rt.
  always_comb begin
    stall_s = 1'b0;
    if (reset) begin
      stall_s = 1'b0;
    end else if (valid_r && mem_read_r && bus.id_valid &&
                 (dest_r != {REGW{1'b0}}) &&
                 ((dest_r == bus.id_rs) || (dest_r == bus.id_rt))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Flush beats hold; the load-use bubble only applies when not held.
  always_comb begin
    bubble_s = bus.flush | (~bus.hold & stall_s);
  end

  // Operand forwarding onto the registered rs/rt values.
  always_comb begin
    fwd_rs_s = forward_pick(rs_r, rs_data_r, bus.exmem_reg_write, bus.exmem_rd,
                            bus.exmem_alu_out, bus.memwb_reg_write, bus.memwb_rd,
                            bus.memwb_data);
    fwd_rt_s = forward_pick(rt_r, rt_data_r, bus.exmem_reg_write, bus.exmem_rd,
                            bus.exmem_alu_out, bus.memwb_reg_write, bus.memwb_rd,
                            bus.memwb_data);
  end

  // Pipeline register: reset/bubble clear everything, hold keeps, else capture.
  always_ff @(posedge clk) begin
    if (reset || bubble_s) begin
      valid_r      <= 1'b0;
      rs_data_r    <= {WIDTH{1'b0}};
      rt_data_r    <= {WIDTH{1'b0}};
      imm_r        <= {WIDTH{1'b0}};
      rs_r         <= {REGW{1'b0}};
      rt_r         <= {REGW{1'b0}};
      dest_r       <= {REGW{1'b0}};
      alu_ctrl_r   <= 3'b000;
      illegal_r    <= 1'b0;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
    end else if (!bus.hold) begin
      valid_r      <= bus.id_valid;
      rs_data_r    <= bus.id_rs_data;
      rt_data_r    <= bus.id_rt_data;
      imm_r        <= bus.id_imm;
      rs_r         <= bus.id_rs;
      rt_r         <= bus.id_rt;
      dest_r       <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      alu_ctrl_r   <= dec_s[2:0];
      illegal_r    <= dec_s[3] & bus.id_valid;
      alu_src_r    <= bus.id_alu_src;
      reg_write_r  <= bus.id_reg_write & bus.id_valid;
      mem_read_r   <= bus.id_mem_read & bus.id_valid;
      mem_write_r  <= bus.id_mem_write & bus.id_valid;
      mem_to_reg_r <= bus.id_mem_to_reg & bus.id_valid;
    end
  end

  assign bus.stall         = stall_s;
  assign bus.ex_valid      = valid_r;
  assign bus.ex_alu_ctrl   = alu_ctrl_r;
  assign bus.ex_a          = fwd_rs_s;
  assign bus.ex_b          = alu_src_r ? imm_r : fwd_rt_s;
  assign bus.ex_store_data = fwd_rt_s;
  assign bus.ex_dest       = dest_r;
  assign bus.ex_reg_write  = reg_write_r;
  assign bus.ex_mem_read   = mem_read_r;
  assign bus.ex_mem_write  = mem_write_r;
  assign bus.ex_mem_to_reg = mem_to_reg_r;
  assign bus.ex_illegal    = illegal_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against an instruction-level
// model of the EX slot.
module tb_id_ex_stage;
  localparam int WIDTH = 32;
  localparam int REGW  = 5;
  localparam logic [5:0] FN_TAB [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  localparam logic [2:0] OP_TAB [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
  } slot_t;

  logic  clk;
  logic  reset;
  slot_t slot;
  int    n_cmp = 0;
  int    n_bad = 0;

  id_ex_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus();
  id_ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] funct);
    if (op == 2'b00) return {1'b0, 3'b010};
    if (op == 2'b01) return {1'b0, 3'b110};
    if (op == 2'b11) return {1'b0, 3'b001};
    for (int i = 0; i < 5; i++) if (FN_TAB[i] == funct) return {1'b0, OP_TAB[i]};
    return {1'b1, 3'b011};
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] regv);
    if (idx != 5'd0 && bus.exmem_reg_write && bus.exmem_rd == idx) return bus.exmem_alu_out;
    if (idx != 5'd0 && bus.memwb_reg_write && bus.memwb_rd == idx) return bus.memwb_data;
    return regv;
  endfunction

  function automatic logic ref_stall();
    logic [4:0] d;
    d = slot.reg_dst ? slot.rd : slot.rt;
    return !reset && slot.valid && slot.mem_read && bus.id_valid && d != 5'd0 &&
           (d == bus.id_rs || d == bus.id_rt);
  endfunction

  function automatic slot_t capture();
    slot_t s;
    s.valid = bus.id_valid;       s.rs_data = bus.id_rs_data; s.rt_data = bus.id_rt_data;
    s.imm = bus.id_imm;           s.rs = bus.id_rs;           s.rt = bus.id_rt;
    s.rd = bus.id_rd;             s.op = bus.id_alu_op;       s.funct = bus.id_funct;
    s.alu_src = bus.id_alu_src;   s.reg_dst = bus.id_reg_dst; s.reg_write = bus.id_reg_write;
    s.mem_read = bus.id_mem_read; s.mem_write = bus.id_mem_write;
    s.mem_to_reg = bus.id_mem_to_reg;
    return s;
  endfunction

  // Model of what sits in the EX slot after each edge.
  always @(posedge clk) begin
    if (reset) slot <= '0;
    else if (bus.flush) slot <= '0;
    else if (bus.hold) slot <= slot;
    else if (ref_stall()) slot <= '0;
    else slot <= capture();
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    logic [3:0]  c;
    logic [31:0] frt;
    #2;
    c   = ref_ctrl(slot.op, slot.funct);
    frt = ref_fwd(slot.rt, slot.rt_data);
    check("stall", bus.stall, ref_stall());
    check("ex_valid", bus.ex_valid, slot.valid);
    check("ex_reg_write", bus.ex_reg_write, slot.valid & slot.reg_write);
    check("ex_mem_read", bus.ex_mem_read, slot.valid & slot.mem_read);
    check("ex_mem_write", bus.ex_mem_write, slot.valid & slot.mem_write);
    check("ex_mem_to_reg", bus.ex_mem_to_reg, slot.valid & slot.mem_to_reg);
    check("ex_illegal", bus.ex_illegal, slot.valid & c[3]);
    if (slot.valid) begin
      check("ex_alu_ctrl", bus.ex_alu_ctrl, c[2:0]);
      check("ex_a", bus.ex_a, ref_fwd(slot.rs, slot.rs_data));
      check("ex_store_data", bus.ex_store_data, frt);
      check("ex_b", bus.ex_b, slot.alu_src ? slot.imm : frt);
      check("ex_dest", bus.ex_dest, slot.reg_dst ? slot.rd : slot.rt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_fwd();
    bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_alu_out = 32'd0;
    bus.memwb_reg_write = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_data = 32'd0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic dst, input logic rw, input logic mr, input logic mw,
                       input logic m2r);
    bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_alu_op = op; bus.id_funct = fn; bus.id_alu_src = src; bus.id_reg_dst = dst;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_mem_to_reg = m2r;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic check_ctrl_zero(input string tag);
    check({tag, "_valid"}, bus.ex_valid, 32'd0);
    check({tag, "_rw"}, bus.ex_reg_write, 32'd0);
    check({tag, "_mr"}, bus.ex_mem_read, 32'd0);
    check({tag, "_mw"}, bus.ex_mem_write, 32'd0);
    check({tag, "_m2r"}, bus.ex_mem_to_reg, 32'd0);
  endtask

  initial begin
    logic [5:0] fl [6];
    logic [2:0] cl [6];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    cl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011};
    reset = 1'b1; bus.flush = 1'b0; bus.hold = 1'b0; idle_fwd();
    instr(5'd8, 5'd9, 5'd10, 32'd5, 32'd7, 32'd0, 2'b10, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with a valid decode slot.
    repeat (2) @(posedge clk);
    #3;
    check_ctrl_zero("rst");
    check("rst_stall", bus.stall, 32'd0);
    check("rst_ctrl", bus.ex_alu_ctrl, 32'd0);
    check("rst_a", bus.ex_a, 32'd0);
    check("rst_b", bus.ex_b, 32'd0);
    check("rst_dest", bus.ex_dest, 32'd0);
    check("rst_illegal", bus.ex_illegal, 32'd0);

    // R-type funct sweep, rs=8 (5), rt=9 (7), rd=10.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset = 1'b0;
      instr(5'd8, 5'd9, 5'd10, 32'd5, 32'd7, 32'd0, 2'b10, fl[i], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      after_edge();
      check("rt_valid", bus.ex_valid, 32'd1);
      check("rt_ctrl", bus.ex_alu_ctrl, cl[i]);
      check("rt_a", bus.ex_a, 32'd5);
      check("rt_b", bus.ex_b, 32'd7);
      check("rt_dest", bus.ex_dest, 32'd10);
      check("rt_illegal", bus.ex_illegal, (i == 5) ? 32'd1 : 32'd0);
    end

    // Forwarding priority on rs=8.
    @(negedge clk);
    instr(5'd8, 5'd1, 5'd10, 32'h55, 32'd7, 32'd0, 2'b10, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd8; bus.exmem_alu_out = 32'h11;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_data = 32'h22;
    after_edge();
    check("fwd_exmem", bus.ex_a, 32'h11);
    bus.exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", bus.ex_a, 32'h22);
    @(negedge clk);
    instr(5'd0, 5'd1, 5'd10, 32'h44, 32'd7, 32'd0, 2'b10, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_alu_out = 32'h33;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'h66;
    after_edge();
    check("fwd_r0", bus.ex_a, 32'h44);

    // Load-use: lw $9 in EX, dependent add in decode.
    @(negedge clk);
    idle_fwd();
    instr(5'd2, 5'd9, 5'd0, 32'h100, 32'd0, 32'd4, 2'b00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    after_edge();
    instr(5'd8, 5'd9, 5'd10, 32'd5, 32'h77, 32'd0, 2'b10, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_stall", bus.stall, 32'd1);
    check("lu_lw_b", bus.ex_b, 32'd4);
    after_edge();
    check_ctrl_zero("lu_bubble");
    check("lu_stall_gone", bus.stall, 32'd0);
    after_edge();
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd9; bus.memwb_data = 32'h99;
    #1;
    check("lu_dep_valid", bus.ex_valid, 32'd1);
    check("lu_dep_b", bus.ex_b, 32'h99);
    check("lu_dep_a", bus.ex_a, 32'd5);

    // Flush together with hold.
    @(negedge clk);
    idle_fwd();
    bus.flush = 1'b1; bus.hold = 1'b1;
    instr(5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 2'b10, 6'h20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    after_edge();
    check_ctrl_zero("flush");

    // Hold for three cycles, then release.
    @(negedge clk);
    bus.flush = 1'b0; bus.hold = 1'b0;
    instr(5'd3, 5'd4, 5'd7, 32'h1234, 32'h5678, 32'hABCD, 2'b10, 6'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    bus.hold = 1'b1;
    instr(5'd5, 5'd6, 5'd12, 32'hBEEF, 32'h1, 32'h0, 2'b10, 6'h25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("hold_a", bus.ex_a, 32'h1234);
      check("hold_b", bus.ex_b, 32'h5678);
      check("hold_ctrl", bus.ex_alu_ctrl, 32'd6);
      check("hold_dest", bus.ex_dest, 32'd7);
    end
    bus.hold = 1'b0;
    after_edge();
    check("rel_a", bus.ex_a, 32'hBEEF);
    check("rel_ctrl", bus.ex_alu_ctrl, 32'd1);
    check("rel_dest", bus.ex_dest, 32'd12);

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.hold = ($urandom_range(0, 5) == 0);
      bus.id_valid = ($urandom_range(0, 4) != 0);
      bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_rd = 5'($urandom_range(0, 3));
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
      bus.id_alu_op = 2'($urandom_range(0, 3));
      bus.id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FN_TAB[$urandom_range(0, 4)];
      bus.id_alu_src = 1'($urandom); bus.id_reg_dst = 1'($urandom);
      bus.id_reg_write = 1'($urandom); bus.id_mem_read = ($urandom_range(0, 2) == 0);
      bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
      bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 3));
      bus.exmem_alu_out = $urandom;
      bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 3));
      bus.memwb_data = $urandom;
    end
    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
